imply_serial_adder: RTL and testbench



---
 rtl/imply_pkg.sv | 12 +
 rtl/FullAdder_Imply.sv | 38 +++
 rtl/imply_serial_adder.sv | 100 ++++++++++
 tb/tb_imply_serial_adder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imply_pkg.sv
// Shared definitions for the IMPLY-logic serial adder: state encoding and default width.
package imply_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/FullAdder_Imply.sv
// Single-bit full adder expressed purely with material implication (p -> q) and constant FALSE.
module FullAdder_Imply (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  function automatic logic imp(input logic p, input logic q);
    return ~p | q;
  endfunction

  function automatic logic inot(input logic x);
    return imp(x, 1'b0);
  endfunction

  function automatic logic iand(input logic x, input logic y);
    return inot(imp(x, inot(y)));
  endfunction

  function automatic logic ior(input logic x, input logic y);
    return imp(inot(x), y);
  endfunction

  function automatic logic ixor(input logic x, input logic y);
    return inot(iand(imp(x, y), imp(y, x)));
  endfunction

  logic w_ab_xor;

  always_comb begin
    w_ab_xor = ixor(A, B);
    Sum      = ixor(w_ab_xor, Cin);
    Cout     = ior(iand(A, B), iand(Cin, w_ab_xor));
  end

endmodule

// File: rtl/imply_serial_adder.sv
// Bit-serial WIDTH-bit adder: one FullAdder_Imply, LSB first, registered carry, valid/ready on both sides.
module imply_serial_adder
  import imply_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_sum_next;

  FullAdder_Imply u_fa (
    .A    (r_a_sh[0]),
    .B    (r_b_sh[0]),
    .Cin  (r_carry),
    .Sum  (w_fa_sum),
    .Cout (w_fa_cout)
  );

  // Written as shift-then-overwrite so the WIDTH=1 build needs no empty slice.
  always_comb begin
    w_sum_next            = r_sum_sh >> 1;
    w_sum_next[WIDTH-1]   = w_fa_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next;
          r_carry  <= w_fa_cout;
          r_cnt    <= r_cnt + CNT_W'(1);
          // Result is copied to dedicated output registers so sum/cout stay put during the next RUN.
          if (r_cnt == LAST_BIT) begin
            r_sum   <= w_sum_next;
            r_cout  <= w_fa_cout;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
    sum       = r_sum;
    cout      = r_cout;
  end

endmodule

// File: tb/tb_imply_serial_adder.sv
// Directed and randomized checks of imply_serial_adder in WIDTH=8 and WIDTH=1 builds.
module tb_imply_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8, cin8, cout8, busy8;
  logic [7:0] a8, b8, s8;
  logic       iv1, ir1, ov1, or1, cin1, cout1, busy1;
  logic [0:0] a1, b1, s1;

  int errors = 0;
  int checks = 0;

  imply_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(cout8), .busy(busy8)
  );

  imply_serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(cout1), .busy(busy1)
  );

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                      output logic [7:0] rs, output logic rc, output int lat);
    int n;
    n = 0;
    while (!ir8 && n < 20) begin @(posedge clk); #1; n++; end
    a8 = ta; b8 = tb_; cin8 = tc; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 64) begin @(posedge clk); #1; lat++; end
    rs = s8; rc = cout8;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ir8 !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", ir8); end
    checks++; if (ov8 !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov8); end
    checks++; if (s8 !== 8'h00)  begin errors++; $display("FAIL reset_sum got=%h exp=00", s8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    checks++; if ({ir1, ov1, busy1} !== 3'b100) begin errors++; $display("FAIL reset_w1_flags got=%b exp=100", {ir1, ov1, busy1}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    logic [7:0] rs; logic rc; int lat;
    run8(8'h00, 8'h00, 1'b0, rs, rc, lat);
    checks++; if (lat !== 8)     begin errors++; $display("FAIL zero_latency got=%0d exp=8", lat); end
    checks++; if (rs !== 8'h00)  begin errors++; $display("FAIL zero_sum got=%h exp=00", rs); end
    checks++; if (rc !== 1'b0)   begin errors++; $display("FAIL zero_cout got=%b exp=0", rc); end
  endtask

  task automatic test_ripple();
    logic [7:0] rs; logic rc; int lat;
    run8(8'hFF, 8'h01, 1'b0, rs, rc, lat);
    checks++; if (rs !== 8'h00) begin errors++; $display("FAIL ripple_sum got=%h exp=00", rs); end
    checks++; if (rc !== 1'b1)  begin errors++; $display("FAIL ripple_cout got=%b exp=1", rc); end
  endtask

  task automatic test_pairs();
    logic [7:0] rs; logic rc; int lat;
    run8(8'hA5, 8'h5A, 1'b1, rs, rc, lat);
    checks++; if (rs !== 8'h00) begin errors++; $display("FAIL pairA_sum got=%h exp=00", rs); end
    checks++; if (rc !== 1'b1)  begin errors++; $display("FAIL pairA_cout got=%b exp=1", rc); end
    run8(8'h3C, 8'h42, 1'b0, rs, rc, lat);
    checks++; if (rs !== 8'h7E) begin errors++; $display("FAIL pairB_sum got=%h exp=7e", rs); end
    checks++; if (rc !== 1'b0)  begin errors++; $display("FAIL pairB_cout got=%b exp=0", rc); end
  endtask

  task automatic test_backpressure();
    int n;
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 64) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      checks++; if (ov8 !== 1'b1)  begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, ov8); end
      checks++; if (s8 !== 8'h34)  begin errors++; $display("FAIL bp_sum cyc=%0d got=%h exp=34", i, s8); end
      checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL bp_cout cyc=%0d got=%b exp=0", i, cout8); end
      checks++; if (ir8 !== 1'b0)  begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, ir8); end
      if (i == 1) begin a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1; end
      if (i == 2) iv8 = 1'b0;
      @(posedge clk); #1;
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    checks++; if ({ov8, ir8, busy8} !== 3'b010) begin errors++; $display("FAIL bp_release_flags got=%b exp=010", {ov8, ir8, busy8}); end
    @(posedge clk); #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL bp_pulse_not_accepted got=%b exp=0", busy8); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] rs; logic rc; int lat;
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    checks++; if ({ir8, ov8, busy8} !== 3'b100) begin errors++; $display("FAIL midrst_flags got=%b exp=100", {ir8, ov8, busy8}); end
    checks++; if (s8 !== 8'h00)   begin errors++; $display("FAIL midrst_sum got=%h exp=00", s8); end
    checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL midrst_cout got=%b exp=0", cout8); end
    @(posedge clk); #1;
    rst = 1'b0;
    run8(8'h12, 8'h34, 1'b0, rs, rc, lat);
    checks++; if (rs !== 8'h46) begin errors++; $display("FAIL postrst_sum got=%h exp=46", rs); end
    checks++; if (rc !== 1'b0)  begin errors++; $display("FAIL postrst_cout got=%b exp=0", rc); end
    checks++; if (lat !== 8)    begin errors++; $display("FAIL postrst_latency got=%0d exp=8", lat); end
  endtask

  task automatic test_back_to_back8();
    int results;
    results = 0;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      logic       rcin, seen, done;
      logic [8:0] exp_v;
      int         lat, n;
      ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom_range(0, 1));
      exp_v = {1'b0, ra} + {1'b0, rb} + {8'h00, rcin};
      n = 0;
      while (!ir8 && n < 20) begin @(posedge clk); #1; n++; end
      a8 = ra; b8 = rb; cin8 = rcin; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      lat = 0; n = 0; seen = 1'b0; done = 1'b0;
      while (!done && n < 200) begin
        if (ov8 && !seen) begin
          seen = 1'b1;
          checks++; if (lat !== 8) begin errors++; $display("FAIL rnd8_latency op=%0d got=%0d exp=8", i, lat); end
        end
        or8 = 1'($urandom_range(0, 1));
        if (ov8 && or8) begin
          checks++;
          if ({cout8, s8} !== exp_v) begin errors++; $display("FAIL rnd8_result op=%0d got=%h exp=%h", i, {cout8, s8}, exp_v); end
          results++; done = 1'b1;
        end
        @(posedge clk); #1;
        if (!seen) lat++;
        n++;
      end
      or8 = 1'b0;
      checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL rnd8_no_dup op=%0d got=%b exp=0", i, ov8); end
    end
    checks++; if (results !== 200) begin errors++; $display("FAIL rnd8_count got=%0d exp=200", results); end
  endtask

  task automatic test_back_to_back1();
    int results;
    results = 0;
    for (int i = 0; i < 200; i++) begin
      logic       ra, rb, rcin, seen, done;
      logic [1:0] exp_v;
      int         lat, n;
      ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1)); rcin = 1'($urandom_range(0, 1));
      exp_v = {1'b0, ra} + {1'b0, rb} + {1'b0, rcin};
      n = 0;
      while (!ir1 && n < 20) begin @(posedge clk); #1; n++; end
      a1 = ra; b1 = rb; cin1 = rcin; iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0;
      lat = 0; n = 0; seen = 1'b0; done = 1'b0;
      while (!done && n < 200) begin
        if (ov1 && !seen) begin
          seen = 1'b1;
          checks++; if (lat !== 1) begin errors++; $display("FAIL rnd1_latency op=%0d got=%0d exp=1", i, lat); end
        end
        or1 = 1'($urandom_range(0, 1));
        if (ov1 && or1) begin
          checks++;
          if ({cout1, s1} !== exp_v) begin errors++; $display("FAIL rnd1_result op=%0d got=%b exp=%b", i, {cout1, s1}, exp_v); end
          results++; done = 1'b1;
        end
        @(posedge clk); #1;
        if (!seen) lat++;
        n++;
      end
      or1 = 1'b0;
      checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL rnd1_no_dup op=%0d got=%b exp=0", i, ov1); end
    end
    checks++; if (results !== 200) begin errors++; $display("FAIL rnd1_count got=%0d exp=200", results); end
  endtask

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    test_reset();
    test_zero();
    test_ripple();
    test_pairs();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back8();
    test_back_to_back1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
